cpu_axi_bridge: RTL and testbench

- Sits directly downstream of the CPU core's memory interfaces.
- Converts the instruction-fetch and data-access sram-like request/response ports into a single AXI3 master for the system interconnect.
- Arbitrates reads between the two CPU ports.
- Keeps at most one read and one write in flight on AXI.
- Enforces one outstanding transaction on the data port, so memory ordering seen by the MEM stage is preserved.

---
 rtl/cpu_axi_bridge.sv | 179 +++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's sram-like instruction and data ports onto a single AXI3 master.
// At most one read and one write are in flight, and the data port has at most one outstanding access.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_B = 2'd2} w_state_e;

    r_state_e            r_state_q, r_state_d;
    w_state_e            w_state_q, w_state_d;
    logic [ID_W-1:0]     arid_q, arid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                data_busy_q, data_busy_d;

    logic r_idle, w_idle, rd_holds_data;
    logic data_rd_acc, data_wr_acc, inst_acc;
    logic r_fire, b_fire;

    // Accept arbitration: a data read outranks a fetch; nothing is accepted during reset.
    always_comb begin
        r_idle        = (r_state_q == R_IDLE);
        w_idle        = (w_state_q == W_IDLE);
        rd_holds_data = ~r_idle & (arid_q == DATA_ID);
        data_rd_acc   = ~reset & r_idle & w_idle & data_req & ~data_wr & ~data_busy_q;
        data_wr_acc   = ~reset & w_idle & data_req & data_wr & ~data_busy_q & ~rd_holds_data;
        inst_acc      = ~reset & r_idle & inst_req & ~data_rd_acc;
        r_fire        = (r_state_q == R_R) & rvalid;
        b_fire        = (w_state_q == W_B) & bvalid;
    end

    assign inst_addr_ok = inst_acc;
    assign data_addr_ok = data_rd_acc | data_wr_acc;
    assign inst_data_ok = r_fire & (rid == INST_ID);
    assign data_data_ok = (r_fire & (rid == DATA_ID)) | b_fire;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_R);
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign awvalid = (w_state_q == W_AW) & ~aw_done_q;
    assign wvalid  = (w_state_q == W_AW) & ~w_done_q;
    assign bready  = (w_state_q == W_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            arid_q      <= '0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            data_busy_q <= data_busy_d;
        end
    end

    // Read channel sequencing.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc) begin
                    arid_d    = DATA_ID;
                    araddr_d  = data_addr;
                    r_state_d = R_AR;
                end else if (inst_acc) begin
                    arid_d    = INST_ID;
                    araddr_d  = inst_addr;
                    r_state_d = R_AR;
                end
            end
            R_AR:    if (arready) r_state_d = R_R;
            R_R:     if (rvalid) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write channel sequencing; AW and W complete independently before waiting on B.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    awaddr_d  = {data_addr[ADDR_W-1:2], 2'b00};
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_AW;
                end
            end
            W_AW: begin
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) w_state_d = W_B;
            end
            W_B:     if (bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // One outstanding data-port access keeps loads ordered behind stores.
    always_comb begin
        data_busy_d = data_busy_q;
        if (data_addr_ok)      data_busy_d = 1'b1;
        else if (data_data_ok) data_busy_d = 1'b0;
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: directed scenarios plus a randomized run against a word-memory reference model.
module tb_cpu_axi_bridge;

    localparam logic [31:0] IBASE = 32'h1c00_0000;
    localparam logic [31:0] DBASE = 32'h1c00_1000;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {logic [3:0] id; logic [31:0] addr;} rd_t;
    typedef struct {bit is_wr; logic [31:0] val;} dexp_t;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Contents of a memory word that has never been stored to.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return init_word(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        arready = 0; rid = '0; rdata = '0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        inst_req = 1; inst_addr = IBASE;
        data_req = 1; data_addr = DBASE;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'b0)
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else n_pass++;
        n_checks++;
        if ({arid, araddr, awaddr, wdata, wstrb} !== 104'b0)
            $display("FAIL reset_regs: got arid=%h araddr=%h awaddr=%h wdata=%h wstrb=%h want all 0",
                     arid, araddr, awaddr, wdata, wstrb);
        else n_pass++;
        step();
        idle_inputs();
        reset = 0;
        settle();
        n_checks++;
        if ({arvalid, awvalid, wvalid, inst_addr_ok, data_addr_ok} !== 5'b0)
            $display("FAIL post_reset_idle: got %b want 00000", {arvalid, awvalid, wvalid, inst_addr_ok, data_addr_ok});
        else n_pass++;
    endtask

    task automatic test_inst_read(input logic [31:0] a, input logic [31:0] d);
        step(); inst_req = 1; inst_addr = a; settle();
        n_checks++;
        if ({inst_addr_ok, data_addr_ok, arvalid} !== 3'b100)
            $display("FAIL inst_accept: got ok/dok/arvalid=%b want 100", {inst_addr_ok, data_addr_ok, arvalid});
        else n_pass++;
        step(); inst_req = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, araddr, inst_data_ok} !== {1'b1, 4'd0, a, 1'b0})
            $display("FAIL inst_ar: got arvalid=%b arid=%h araddr=%h want 1 0 %h", arvalid, arid, araddr, a);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd0; rdata = d; settle();
        n_checks++;
        if ({rready, inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 1'b1, d, 1'b0})
            $display("FAIL inst_r: got rready=%b ok=%b rdata=%h dok=%b want 1 1 %h 0",
                     rready, inst_data_ok, inst_rdata, data_data_ok, d);
        else n_pass++;
        step(); rvalid = 0; settle();
        n_checks++;
        if ({arvalid, rready, inst_data_ok} !== 3'b000)
            $display("FAIL inst_done: got %b want 000", {arvalid, rready, inst_data_ok});
        else n_pass++;
    endtask

    task automatic test_arbitration();
        logic [31:0] ia, dd, id;
        ia = IBASE + 32'h40; dd = $urandom; id = $urandom;
        step();
        inst_req = 1; inst_addr = ia;
        data_req = 1; data_wr = 0; data_addr = DBASE;
        settle();
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL arb_winner: got data_ok/inst_ok=%b want 10", {data_addr_ok, inst_addr_ok});
        else n_pass++;
        step(); data_req = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, araddr, inst_addr_ok} !== {1'b1, 4'd1, DBASE, 1'b0})
            $display("FAIL arb_ar: got arvalid=%b arid=%h araddr=%h inst_ok=%b want 1 1 %h 0",
                     arvalid, arid, araddr, inst_addr_ok, DBASE);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd1; rdata = dd; settle();
        n_checks++;
        if ({data_data_ok, data_rdata, inst_data_ok, inst_addr_ok} !== {1'b1, dd, 1'b0, 1'b0})
            $display("FAIL arb_r: got dok=%b rdata=%h iok=%b iaok=%b want 1 %h 0 0",
                     data_data_ok, data_rdata, inst_data_ok, inst_addr_ok, dd);
        else n_pass++;
        step(); rvalid = 0; settle();
        n_checks++;
        if (inst_addr_ok !== 1'b1) $display("FAIL arb_inst_next: got %b want 1", inst_addr_ok);
        else n_pass++;
        step(); inst_req = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd0, ia})
            $display("FAIL arb_inst_ar: got arvalid=%b arid=%h araddr=%h want 1 0 %h", arvalid, arid, araddr, ia);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd0; rdata = id; settle();
        n_checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, id, 1'b0})
            $display("FAIL arb_inst_r: got ok=%b rdata=%h dok=%b want 1 %h 0", inst_data_ok, inst_rdata, data_data_ok, id);
        else n_pass++;
        step(); rvalid = 0;
    endtask

    task automatic test_store();
        step();
        data_req = 1; data_wr = 1; data_addr = 32'h1c00_2002; data_wdata = 32'h1234_5678; data_wstrb = 4'b0011;
        settle();
        n_checks++;
        if (data_addr_ok !== 1'b1) $display("FAIL st_accept: got %b want 1", data_addr_ok);
        else n_pass++;
        step(); data_req = 0; wready = 1; settle();
        n_checks++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h1c00_2000, 32'h1234_5678, 4'b0011})
            $display("FAIL st_aw_w: got aw=%b w=%b awaddr=%h wdata=%h wstrb=%b want 1 1 1c002000 12345678 0011",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        else n_pass++;
        step(); wready = 0; settle();
        n_checks++;
        if ({awvalid, wvalid} !== 2'b10) $display("FAIL st_w_drop: got aw/w=%b want 10", {awvalid, wvalid});
        else n_pass++;
        step(); awready = 1; settle();
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b100)
            $display("FAIL st_aw_hold: got aw/w/b=%b want 100", {awvalid, wvalid, bready});
        else n_pass++;
        step(); awready = 0; settle();
        n_checks++;
        if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010)
            $display("FAIL st_wait_b: got aw/w/bready/dok=%b want 0010", {awvalid, wvalid, bready, data_data_ok});
        else n_pass++;
        step(); bvalid = 1; settle();
        n_checks++;
        if (data_data_ok !== 1'b1) $display("FAIL st_b: got %b want 1", data_data_ok);
        else n_pass++;
        step(); bvalid = 0; settle();
        n_checks++;
        if ({bready, data_data_ok} !== 2'b00) $display("FAIL st_done: got %b want 00", {bready, data_data_ok});
        else n_pass++;
    endtask

    task automatic test_store_blocks_read();
        logic [31:0] ia, la, d1, d2;
        ia = IBASE + 32'h80; la = DBASE + 32'h10; d1 = $urandom; d2 = $urandom;
        step();
        data_req = 1; data_wr = 1; data_addr = DBASE + 32'h20; data_wdata = $urandom; data_wstrb = 4'hf;
        settle();
        n_checks++;
        if (data_addr_ok !== 1'b1) $display("FAIL sb_store_accept: got %b want 1", data_addr_ok);
        else n_pass++;
        step(); data_wr = 0; data_addr = la; inst_req = 1; inst_addr = ia; awready = 1; wready = 1; settle();
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b01)
            $display("FAIL sb_block: got data_ok/inst_ok=%b want 01", {data_addr_ok, inst_addr_ok});
        else n_pass++;
        step(); inst_req = 0; awready = 0; wready = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, bready, data_addr_ok} !== {1'b1, 4'd0, 1'b1, 1'b0})
            $display("FAIL sb_inst_ar: got arvalid=%b arid=%h bready=%b dok=%b want 1 0 1 0",
                     arvalid, arid, bready, data_addr_ok);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd0; rdata = d1; settle();
        n_checks++;
        if ({inst_data_ok, inst_rdata, data_addr_ok} !== {1'b1, d1, 1'b0})
            $display("FAIL sb_inst_r: got ok=%b rdata=%h daok=%b want 1 %h 0", inst_data_ok, inst_rdata, data_addr_ok, d1);
        else n_pass++;
        step(); rvalid = 0; bvalid = 1; settle();
        n_checks++;
        if ({data_data_ok, data_addr_ok} !== 2'b10)
            $display("FAIL sb_store_done: got dok/daok=%b want 10", {data_data_ok, data_addr_ok});
        else n_pass++;
        step(); bvalid = 0; settle();
        n_checks++;
        if (data_addr_ok !== 1'b1) $display("FAIL sb_read_accept: got %b want 1", data_addr_ok);
        else n_pass++;
        step(); data_req = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd1, la})
            $display("FAIL sb_read_ar: got arvalid=%b arid=%h araddr=%h want 1 1 %h", arvalid, arid, araddr, la);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd1; rdata = d2; settle();
        n_checks++;
        if ({data_data_ok, data_rdata} !== {1'b1, d2})
            $display("FAIL sb_read_r: got ok=%b rdata=%h want 1 %h", data_data_ok, data_rdata, d2);
        else n_pass++;
        step(); rvalid = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = $urandom;
        step(); inst_req = 1; inst_addr = IBASE + 32'hc0;
        step(); inst_req = 0; settle();
        n_checks++;
        if (arvalid !== 1'b1) $display("FAIL rm_in_ar: got %b want 1", arvalid);
        else n_pass++;
        #1 reset = 1;
        #1;
        n_checks++;
        if ({arvalid, rready, inst_data_ok, data_data_ok, arid, araddr} !== 40'b0)
            $display("FAIL rm_async: got arvalid=%b rready=%b iok=%b dok=%b arid=%h araddr=%h want all 0",
                     arvalid, rready, inst_data_ok, data_data_ok, arid, araddr);
        else n_pass++;
        step(); step(); reset = 0; settle();
        n_checks++;
        if ({arvalid, rready, inst_data_ok, data_data_ok} !== 4'b0)
            $display("FAIL rm_released: got %b want 0000", {arvalid, rready, inst_data_ok, data_data_ok});
        else n_pass++;
        step(); data_req = 1; data_wr = 0; data_addr = DBASE + 32'h4; settle();
        n_checks++;
        if (data_addr_ok !== 1'b1) $display("FAIL rm_accept: got %b want 1", data_addr_ok);
        else n_pass++;
        step(); data_req = 0; arready = 1; settle();
        n_checks++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd1, DBASE + 32'h4})
            $display("FAIL rm_ar: got arvalid=%b arid=%h araddr=%h want 1 1 %h", arvalid, arid, araddr, DBASE + 32'h4);
        else n_pass++;
        step(); arready = 0; rvalid = 1; rid = 4'd1; rdata = d; settle();
        n_checks++;
        if ({data_data_ok, data_rdata} !== {1'b1, d})
            $display("FAIL rm_r: got ok=%b rdata=%h want 1 %h", data_data_ok, data_rdata, d);
        else n_pass++;
        step(); rvalid = 0;
    endtask

    // Random CPU traffic and AXI back-pressure; loads must return the reference memory's word.
    task automatic test_random(input int cycles);
        rd_t         rd_q[$];
        logic [31:0] inst_exp[$];
        dexp_t       data_exp[$];
        bit          aw_got, w_got, b_pend, inst_taken, data_taken, gen, quiet;
        logic [31:0] aw_a, w_d, wa;
        logic [3:0]  w_s;
        aw_got = 0; w_got = 0; b_pend = 0; inst_taken = 0; data_taken = 0; quiet = 0;
        aw_a = '0; w_d = '0; w_s = '0;
        ref_mem.delete();
        slv_mem.delete();
        for (int cyc = 0; cyc < cycles + 400; cyc++) begin
            step();
            gen = (cyc < cycles);
            if (inst_taken) inst_req = 0;
            if (data_taken) data_req = 0;
            inst_taken = 0; data_taken = 0;
            if (gen && !inst_req && $urandom_range(0, 2) == 0) begin
                inst_req  = 1;
                inst_addr = IBASE + 32'($urandom_range(0, 15)) * 32'd4;
            end
            if (gen && !data_req && $urandom_range(0, 1) == 0) begin
                data_req   = 1;
                data_wr    = 1'($urandom_range(0, 1));
                data_addr  = DBASE + 32'($urandom_range(0, 7)) * 32'd4 + (data_wr ? 32'($urandom_range(0, 3)) : 32'd0);
                data_wdata = $urandom;
                data_wstrb = 4'($urandom_range(1, 15));
            end
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            if (rd_q.size() != 0 && $urandom_range(0, 2) != 0) begin
                rvalid = 1; rid = rd_q[0].id; rdata = slv_rd(rd_q[0].addr);
            end else begin
                rvalid = 0; rid = '0; rdata = $urandom;
            end
            bvalid = b_pend && ($urandom_range(0, 1) == 1);
            quiet = !inst_req && !data_req && inst_exp.size() == 0 && data_exp.size() == 0 &&
                    rd_q.size() == 0 && !b_pend && !aw_got && !w_got;
            if (!gen && quiet) break;
            settle();
            if (inst_addr_ok) begin
                inst_exp.push_back(init_word(inst_addr));
                inst_taken = 1;
            end
            if (data_addr_ok) begin
                n_checks++;
                if (data_exp.size() != 0)
                    $display("FAIL rnd_data_outstanding: got %0d pending want 0", data_exp.size());
                else n_pass++;
                if (data_wr) begin
                    wa = {data_addr[31:2], 2'b00};
                    ref_mem[wa] = merge(ref_rd(wa), data_wdata, data_wstrb);
                    data_exp.push_back('{1'b1, 32'd0});
                end else begin
                    data_exp.push_back('{1'b0, ref_rd(data_addr)});
                end
                data_taken = 1;
            end
            if (inst_data_ok) begin
                n_checks++;
                if (inst_exp.size() == 0)
                    $display("FAIL rnd_inst_resp: got unexpected data %h want none", inst_rdata);
                else if (inst_rdata !== inst_exp[0])
                    $display("FAIL rnd_inst_resp: got %h want %h", inst_rdata, inst_exp[0]);
                else n_pass++;
                if (inst_exp.size() != 0) void'(inst_exp.pop_front());
            end
            if (data_data_ok) begin
                n_checks++;
                if (data_exp.size() == 0)
                    $display("FAIL rnd_data_resp: got unexpected data_ok want none");
                else if (!data_exp[0].is_wr && data_rdata !== data_exp[0].val)
                    $display("FAIL rnd_data_resp: got %h want %h", data_rdata, data_exp[0].val);
                else n_pass++;
                if (data_exp.size() != 0) void'(data_exp.pop_front());
            end
            if (arvalid && arready) rd_q.push_back('{arid, araddr});
            if (rvalid && rready && rd_q.size() != 0) void'(rd_q.pop_front());
            if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; end
            if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; end
            if (aw_got && w_got) begin
                slv_mem[aw_a] = merge(slv_rd(aw_a), w_d, w_s);
                aw_got = 0; w_got = 0; b_pend = 1;
            end
            if (bvalid && bready) b_pend = 0;
        end
        idle_inputs();
        n_checks++;
        if (!quiet)
            $display("FAIL rnd_drain: got inst_pend=%0d data_pend=%0d rd_pend=%0d b_pend=%0d want all 0",
                     inst_exp.size(), data_exp.size(), rd_q.size(), b_pend);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_inst_read(32'h1c00_0000, 32'h0280_0c0c);
        for (int i = 0; i < 3; i++) test_inst_read(IBASE + 32'($urandom_range(0, 255)) * 32'd4, $urandom);
        test_arbitration();
        test_store();
        test_store_blocks_read();
        test_reset_mid();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
